// File: rtl/mult_unit_pkg.sv
// Shared definitions for the iterative HI/LO multiplier: FSM state encoding,
// default operand width and iteration-counter width.
package mult_pkg;

  // Multiplier sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } multState_t;

  // Default operand width; the product is twice this wide
  localparam int MULT_WIDTH = 32;

  // Counter must hold 0..MULT_WIDTH-1 with headroom for the terminal compare
  localparam int MULT_CNT_WIDTH = $clog2(MULT_WIDTH) + 1;

endpackage

// File: rtl/mult_unit.sv
// Iterative radix-2 shift-add multiplier with architectural HI/LO registers.
// A start in IDLE latches operand magnitudes and the result sign, RUN adds
// one partial product per cycle, FIX applies the sign and commits {HI,LO}.
// pve is registered and high only in IDLE; busy is its complement.
module mult_unit
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             multstartE,
  input  logic             multsignedE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             wehi,
  input  logic             welo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             pve,
  output logic             busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  multState_t       state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]    acc;
  logic [CW-1:0]    cnt;
  logic             negResult;
  logic [WIDTH-1:0] hiReg;
  logic [WIDTH-1:0] loReg;
  logic             pveReg;
  logic             busyReg;

  logic [PW-1:0]    magA;
  logic [PW-1:0]    magB;
  logic [PW-1:0]    addend;
  logic [PW-1:0]    finalProd;
  logic             unusedMagHi;

  // Two's-complement negate at product width when neg is set. Operands are
  // zero-extended first, so the low WIDTH bits are their magnitude; this also
  // maps -2^(WIDTH-1) to 2^(WIDTH-1), which fits an unsigned WIDTH-bit field.
  function automatic logic [PW-1:0] condNegate(input logic [PW-1:0] v, input logic neg);
    condNegate = neg ? (~v + PW'(1)) : v;
  endfunction

  // Operand magnitudes, current partial product and the signed final result
  always_comb begin
    magA      = condNegate({{WIDTH{1'b0}}, srcaE}, multsignedE & srcaE[WIDTH-1]);
    magB      = condNegate({{WIDTH{1'b0}}, srcbE}, multsignedE & srcbE[WIDTH-1]);
    addend    = {{WIDTH{1'b0}}, mcand} << cnt;
    finalProd = condNegate(acc, negResult);
  end

  // Only the low half of each operand magnitude is meaningful
  assign unusedMagHi = ^{magA[PW-1:WIDTH], magB[PW-1:WIDTH]};

  // Sequencer and datapath; HI/LO move only on FIX or an IDLE MTHI/MTLO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      negResult <= 1'b0;
      hiReg     <= '0;
      loReg     <= '0;
      pveReg    <= 1'b1;
      busyReg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (multstartE) begin
            // A start wins over a same-cycle MTHI/MTLO, which is dropped
            mcand     <= magA[WIDTH-1:0];
            mplier    <= magB[WIDTH-1:0];
            negResult <= multsignedE & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
            acc       <= '0;
            cnt       <= '0;
            state     <= RUN;
            pveReg    <= 1'b0;
            busyReg   <= 1'b1;
          end else begin
            if (wehi) hiReg <= wdata;
            if (welo) loReg <= wdata;
          end
        end
        RUN: begin
          if (mplier[0]) acc <= acc + addend;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST_ITER) state <= FIX;
        end
        FIX: begin
          {hiReg, loReg} <= finalProd;
          state          <= IDLE;
          pveReg         <= 1'b1;
          busyReg        <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          pveReg  <= 1'b1;
          busyReg <= 1'b0;
        end
      endcase
    end
  end

  assign hi   = hiReg;
  assign lo   = loReg;
  assign pve  = pveReg;
  assign busy = busyReg;

endmodule

// File: tb/tb_mult_unit.sv
// Scoreboard bench for mult_unit: expected products are queued when a start
// is driven and popped when pve returns high; a monitor watches pve/busy
// consistency and HI/LO stability while a product is pending.
module tb_mult_unit;
  import mult_pkg::*;

  localparam int W = MULT_WIDTH;
  localparam int FULL_LAT = W + 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         multstartE;
  logic         multsignedE;
  logic [W-1:0] srcaE;
  logic [W-1:0] srcbE;
  logic         wehi;
  logic         welo;
  logic [W-1:0] wdata;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         pve;
  logic         busy;

  logic [63:0]  sb[$];
  int           vectorsApplied = 0;
  int           miscompares = 0;
  bit           monOn = 1'b0;
  logic         prevPve = 1'b1;
  logic [W-1:0] prevHi = '0;
  logic [W-1:0] prevLo = '0;
  logic [W-1:0] savedLo;

  always #5 clk = ~clk;

  mult_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .multstartE (multstartE),
    .multsignedE(multsignedE),
    .srcaE      (srcaE),
    .srcbE      (srcbE),
    .wehi       (wehi),
    .welo       (welo),
    .wdata      (wdata),
    .hi         (hi),
    .lo         (lo),
    .pve        (pve),
    .busy       (busy)
  );

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectorsApplied++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference product using native 64-bit arithmetic
  function automatic logic [63:0] refProd(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic signed [63:0] sa;
    logic signed [63:0] sbv;
    if (s) begin
      sa  = {{W{a[W-1]}}, a};
      sbv = {{W{b[W-1]}}, b};
      return sa * sbv;
    end
    return {{W{1'b0}}, a} * {{W{1'b0}}, b};
  endfunction

  // Called at a falling edge; drives a start for one cycle and queues the result
  task automatic startOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    multstartE  = 1'b1;
    multsignedE = s;
    srcaE       = a;
    srcbE       = b;
    sb.push_back(refProd(a, b, s));
    @(negedge clk);
    multstartE  = 1'b0;
    wehi        = 1'b0;
    welo        = 1'b0;
    srcaE       = $urandom;
    srcbE       = $urandom;
    multsignedE = 1'($urandom_range(0, 1));
  endtask

  // Counts remaining pending cycles, then checks latency and the popped product
  task automatic waitDone(input string tag, input int expLat);
    int cycles = 0;
    logic [63:0] exp;
    while (pve !== 1'b1 && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
    checkVal({tag, "_lat"}, 64'(cycles), 64'(expLat));
    checkVal({tag, "_sbDepth"}, 64'(sb.size()), 64'd1);
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      checkVal({tag, "_hilo"}, {hi, lo}, exp);
      $display("%s: hi=%08h lo=%08h expected=%016h lat=%0d", tag, hi, lo, exp, cycles);
    end
  endtask

  // Continuous invariants once out of the initial reset
  always @(negedge clk) begin
    if (monOn && !reset) begin
      checkVal("pveXorBusy", 64'(pve ^ busy), 64'd1);
      if (prevPve === 1'b0 && pve === 1'b0) begin
        checkVal("hiHold", 64'(hi), 64'(prevHi));
        checkVal("loHold", 64'(lo), 64'(prevLo));
      end
      prevPve = pve;
      prevHi  = hi;
      prevLo  = lo;
    end
  end

  initial begin
    reset       = 1'b1;
    multstartE  = 1'b0;
    multsignedE = 1'b0;
    srcaE       = '0;
    srcbE       = '0;
    wehi        = 1'b0;
    welo        = 1'b0;
    wdata       = '0;
    repeat (2) @(negedge clk);
    checkVal("rstHi", 64'(hi), 64'd0);
    checkVal("rstLo", 64'(lo), 64'd0);
    checkVal("rstPve", 64'(pve), 64'd1);
    checkVal("rstBusy", 64'(busy), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    monOn = 1'b1;

    // MTHI / MTLO in IDLE
    wehi = 1'b1; wdata = 32'h0000_1234;
    @(negedge clk);
    wehi = 1'b0;
    checkVal("mthi", 64'(hi), 64'h1234);
    welo = 1'b1; wdata = 32'h0000_5678;
    @(negedge clk);
    welo = 1'b0;
    checkVal("mtlo", 64'(lo), 64'h5678);
    $display("mthi/mtlo: hi=%08h lo=%08h", hi, lo);

    // Directed corner products
    startOp(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    waitDone("multuMax", FULL_LAT);
    checkVal("multuMaxConst", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    startOp(32'hFFFF_FFF9, 32'h0000_0003, 1'b1);
    waitDone("multNeg7x3", FULL_LAT);
    checkVal("multNeg7x3Const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    startOp(32'h8000_0000, 32'h8000_0000, 1'b1);
    waitDone("multMinSq", FULL_LAT);
    checkVal("multMinSqConst", {hi, lo}, 64'h4000_0000_0000_0000);

    // Start during RUN is ignored; next start in first pve=1 cycle is accepted
    startOp(32'h0123_4567, 32'h0008_9ABC, 1'b0);
    repeat (4) @(negedge clk);
    multstartE = 1'b1; multsignedE = 1'b1; srcaE = 32'hDEAD_0001; srcbE = 32'h7777_0003;
    @(negedge clk);
    multstartE = 1'b0;
    waitDone("ignoredStart", FULL_LAT - 5);
    startOp(32'h8765_4321, 32'hFEDC_BA98, 1'b1);
    waitDone("backToBack", FULL_LAT);

    // MTLO during RUN leaves LO untouched
    startOp(32'h0000_1000, 32'h0000_0010, 1'b1);
    repeat (3) @(negedge clk);
    savedLo = lo;
    welo = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    welo = 1'b0;
    checkVal("mtloDuringRun", 64'(lo), 64'(savedLo));
    waitDone("mtloRunOp", FULL_LAT - 4);

    // Start and MTLO together in IDLE: the start wins
    welo = 1'b1; wdata = 32'h0000_CAFE;
    startOp(32'hFFFF_FFFE, 32'h0000_0005, 1'b1);
    waitDone("startPlusMtlo", FULL_LAT);

    // Asynchronous reset around iteration 10
    startOp(32'h1357_9BDF, 32'h2468_ACE0, 1'b0);
    repeat (9) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    checkVal("midRstPve", 64'(pve), 64'd1);
    checkVal("midRstBusy", 64'(busy), 64'd0);
    checkVal("midRstHi", 64'(hi), 64'd0);
    checkVal("midRstLo", 64'(lo), 64'd0);
    $display("reset mid-run: pve=%0b busy=%0b hi=%08h lo=%08h", pve, busy, hi, lo);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    startOp(32'h0000_0007, 32'hFFFF_FFFF, 1'b1);
    waitDone("afterReset", FULL_LAT);

    // Randomized MULT/MULTU against the 64-bit reference
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: a = 32'h8000_0000;
        1: b = 32'hFFFF_FFFF;
        2: a = '0;
        default: ;
      endcase
      startOp(a, b, 1'($urandom_range(0, 1)));
      waitDone("rnd", FULL_LAT);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
